// File: rtl/pe_array_ctrl.sv
// Sequencer for a column of convolution PEs: clears weights, loads a KxK kernel, streams the ifmap, waits for every psum.
// Optional macro PE_ARRAY_CTRL_PERF_EN adds perf_cycles_o, a saturating count of busy cycles from CLR through DRAIN.
module pe_array_ctrl #(
   parameter int G_BUF_ADDR_WIDTH = 10,
   parameter int G_TOP_BITS       = 2,
   parameter int G_BOT_BITS       = 14,
   parameter int G_KERNEL_SIZE    = 5,
   parameter int G_IMAGE_HEIGHT   = 28,
   parameter int G_IMAGE_WIDTH    = 28,
   parameter int G_NUM_PE         = 5
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               start_i,
   input  logic                               abort_i,
   input  logic [G_BUF_ADDR_WIDTH-1:0]        wt_base_i,
   input  logic [G_BUF_ADDR_WIDTH-1:0]        if_base_i,
   output logic                               busy_o,
   output logic                               done_o,
   output logic                               buf_rd_en_o,
   output logic [G_BUF_ADDR_WIDTH-1:0]        buf_rd_addr_o,
   input  logic [G_TOP_BITS+G_BOT_BITS-1:0]   buf_rd_data_i,
   output logic                               weight_clr_o,
   output logic [G_NUM_PE-1:0]                weight_vld_o,
   output logic [G_TOP_BITS+G_BOT_BITS-1:0]   weight_o,
   output logic                               ifmap_vld_o,
   output logic                               ifmap_row_o,
   output logic [G_TOP_BITS+G_BOT_BITS-1:0]   ifmap_o,
   output logic [2:0]                         state_o,
   input  logic                               psum_vld_i
`ifdef PE_ARRAY_CTRL_PERF_EN
   ,
   output logic [31:0]                        perf_cycles_o
`endif
);

   localparam int NW     = G_KERNEL_SIZE * G_KERNEL_SIZE;
   localparam int NI     = G_IMAGE_HEIGHT * G_IMAGE_WIDTH;
   localparam int NOUT   = (G_IMAGE_HEIGHT - G_KERNEL_SIZE + 1) * (G_IMAGE_WIDTH - G_KERNEL_SIZE + 1);
   localparam int MAX_R  = (G_IMAGE_HEIGHT > G_KERNEL_SIZE) ? G_IMAGE_HEIGHT : G_KERNEL_SIZE;
   localparam int MAX_C  = (G_IMAGE_WIDTH > G_KERNEL_SIZE) ? G_IMAGE_WIDTH : G_KERNEL_SIZE;
   localparam int IDX_W  = $clog2(NI + 1);
   localparam int ROW_W  = $clog2(MAX_R + 1);
   localparam int COL_W  = $clog2(MAX_C + 1);
   localparam int CNT_W  = $clog2(NOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_WLOAD = 3'd2,
      S_IFEED = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                      state_q, state_d;
   logic [G_BUF_ADDR_WIDTH-1:0] wt_base_q, if_base_q;
   logic [IDX_W-1:0]            idx_q;
   logic [ROW_W-1:0]            row_q, dly_row_q;
   logic [COL_W-1:0]            col_q;
   logic [CNT_W-1:0]            psum_cnt_q;
   logic                        dly_wt_q, dly_if_q;
   logic                        rd_en, last_rd, row_end, counting, psum_full;
   logic [G_BUF_ADDR_WIDTH-1:0] rd_addr;

   assign counting  = (state_q == S_WLOAD) || (state_q == S_IFEED) || (state_q == S_DRAIN);
   assign psum_full = (psum_cnt_q == CNT_W'(NOUT));

   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      rd_addr = '0;
      last_rd = 1'b0;
      row_end = 1'b0;
      case (state_q)
         S_IDLE:  if (start_i) state_d = S_CLR;
         S_CLR:   state_d = S_WLOAD;
         S_WLOAD: begin
            rd_en   = 1'b1;
            rd_addr = wt_base_q + G_BUF_ADDR_WIDTH'(idx_q);
            row_end = (col_q == COL_W'(G_KERNEL_SIZE - 1));
            last_rd = (idx_q == IDX_W'(NW - 1));
            if (last_rd) state_d = S_IFEED;
         end
         S_IFEED: begin
            rd_en   = 1'b1;
            rd_addr = if_base_q + G_BUF_ADDR_WIDTH'(idx_q);
            row_end = (col_q == COL_W'(G_IMAGE_WIDTH - 1));
            last_rd = (idx_q == IDX_W'(NI - 1));
            if (last_rd) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // A pulse landing in this cycle may complete the count.
            if (psum_full || (psum_vld_i && psum_cnt_q == CNT_W'(NOUT - 1))) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort_i && state_q != S_IDLE) begin
         state_d = S_IDLE;
         rd_en   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         wt_base_q  <= '0;
         if_base_q  <= '0;
         idx_q      <= '0;
         row_q      <= '0;
         col_q      <= '0;
         psum_cnt_q <= '0;
         dly_wt_q   <= 1'b0;
         dly_if_q   <= 1'b0;
         dly_row_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && start_i) begin
            wt_base_q <= wt_base_i;
            if_base_q <= if_base_i;
         end
         // row_q is the kernel row during WLOAD and the image row during IFEED.
         if (state_q == S_CLR || last_rd) begin
            idx_q <= '0;
            row_q <= '0;
            col_q <= '0;
         end else if (rd_en) begin
            idx_q <= idx_q + 1'b1;
            if (row_end) begin
               col_q <= '0;
               row_q <= row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end
         if (state_q == S_CLR) psum_cnt_q <= '0;
         else if (counting && psum_vld_i && !psum_full) psum_cnt_q <= psum_cnt_q + 1'b1;
         dly_wt_q  <= rd_en && (state_q == S_WLOAD);
         dly_if_q  <= rd_en && (state_q == S_IFEED);
         dly_row_q <= row_q;
      end
   end

`ifdef PE_ARRAY_CTRL_PERF_EN
   logic [31:0] perf_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) perf_q <= '0;
      else if (state_q == S_IDLE && start_i) perf_q <= '0;
      else if ((state_q == S_CLR || counting) && perf_q != '1) perf_q <= perf_q + 32'd1;
   end
   assign perf_cycles_o = perf_q;
`endif

   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = (state_q == S_DONE);
   assign weight_clr_o  = (state_q == S_CLR);
   assign buf_rd_en_o   = rd_en;
   assign buf_rd_addr_o = rd_addr;
   assign weight_vld_o  = dly_wt_q ? (G_NUM_PE'(1) << dly_row_q) : '0;
   assign weight_o      = dly_wt_q ? buf_rd_data_i : '0;
   assign ifmap_vld_o   = dly_if_q;
   assign ifmap_row_o   = dly_if_q & ~dly_row_q[0];
   assign ifmap_o       = dly_if_q ? buf_rd_data_i : '0;
   assign state_o       = state_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Randomized bench for pe_array_ctrl (K=3, H=W=4): per-cycle timeline model plus an expected-data queue.
// Build with PE_ARRAY_CTRL_PERF_EN defined to also check perf_cycles_o.
module tb_pe_array_ctrl;

   localparam int AW = 10, DW = 16, K = 3, H = 4, W = 4, NPE = 3;
   localparam int NW = K * K, NI = H * W, NOUT = (H - K + 1) * (W - K + 1);
   localparam int D_T = 1 + NW + NI;  // first DRAIN cycle, counted from the CLR cycle
   localparam int PLAN_LEN = 64;

   // ---------------- clock / reset / DUT ----------------
   logic clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, abort_i = 1'b0, psum_vld_i = 1'b0;
   logic [AW-1:0] wt_base_i = '0, if_base_i = '0, buf_rd_addr_o;
   logic [DW-1:0] buf_rd_data_i = '0, weight_o, ifmap_o;
   logic busy_o, done_o, buf_rd_en_o, weight_clr_o, ifmap_vld_o, ifmap_row_o;
   logic [NPE-1:0] weight_vld_o;
   logic [2:0] state_o;
`ifdef PE_ARRAY_CTRL_PERF_EN
   logic [31:0] perf_cycles_o;
`endif

   always #5 clk_i = ~clk_i;

   pe_array_ctrl #(
      .G_BUF_ADDR_WIDTH(AW), .G_TOP_BITS(2), .G_BOT_BITS(14), .G_KERNEL_SIZE(K),
      .G_IMAGE_HEIGHT(H), .G_IMAGE_WIDTH(W), .G_NUM_PE(NPE)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
      .wt_base_i(wt_base_i), .if_base_i(if_base_i), .busy_o(busy_o), .done_o(done_o),
      .buf_rd_en_o(buf_rd_en_o), .buf_rd_addr_o(buf_rd_addr_o), .buf_rd_data_i(buf_rd_data_i),
      .weight_clr_o(weight_clr_o), .weight_vld_o(weight_vld_o), .weight_o(weight_o),
      .ifmap_vld_o(ifmap_vld_o), .ifmap_row_o(ifmap_row_o), .ifmap_o(ifmap_o),
      .state_o(state_o), .psum_vld_i(psum_vld_i)
`ifdef PE_ARRAY_CTRL_PERF_EN
      , .perf_cycles_o(perf_cycles_o)
`endif
   );

   // Global buffer: one-cycle read latency, garbage on the bus when not reading.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk_i) begin
      if (buf_rd_en_o) buf_rd_data_i <= mem[buf_rd_addr_o];
      else buf_rd_data_i <= DW'($urandom);
   end

   // ---------------- scoreboard ----------------
   int n_total = 0, n_bad = 0;
   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] cur_wb, cur_ib;
   bit plan [0:PLAN_LEN-1];  // psum_vld_i schedule, indexed by cycle from CLR

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag, input bit full);
      chk({tag, ":busy"}, 32'(busy_o), 0);
      chk({tag, ":done"}, 32'(done_o), 0);
      chk({tag, ":rd_en"}, 32'(buf_rd_en_o), 0);
      chk({tag, ":clr"}, 32'(weight_clr_o), 0);
      chk({tag, ":weight_vld"}, 32'(weight_vld_o), 0);
      chk({tag, ":ifmap_vld"}, 32'(ifmap_vld_o), 0);
      chk({tag, ":state"}, 32'(state_o), 0);
      if (full) begin
         chk({tag, ":rd_addr"}, 32'(buf_rd_addr_o), 0);
         chk({tag, ":weight"}, 32'(weight_o), 0);
         chk({tag, ":ifmap"}, 32'(ifmap_o), 0);
         chk({tag, ":ifmap_row"}, 32'(ifmap_row_o), 0);
      end
   endtask

   // Expected outputs at cycle tt of a run (tt=0 is the CLR cycle).
   task automatic check_cycle(input int tt, input int done_t);
      logic [AW-1:0] a;
      logic [NPE-1:0] wv;
      logic [DW-1:0] ed;
      int j;
      chk("busy", 32'(busy_o), 32'(tt <= done_t));
      chk("clr", 32'(weight_clr_o), 32'(tt == 0));
      chk("done", 32'(done_o), 32'(tt == done_t));
      chk("rd_en", 32'(buf_rd_en_o), 32'(tt >= 1 && tt <= NW + NI));
      if (tt >= 1 && tt <= NW) begin
         a = cur_wb + AW'(tt - 1);
         chk("rd_addr_wt", 32'(buf_rd_addr_o), 32'(a));
      end else if (tt > NW && tt <= NW + NI) begin
         a = cur_ib + AW'(tt - 1 - NW);
         chk("rd_addr_if", 32'(buf_rd_addr_o), 32'(a));
      end
      wv = '0;
      if (tt >= 2 && tt <= NW + 1) wv = NPE'(1) << ((tt - 2) / K);
      chk("weight_vld", 32'(weight_vld_o), 32'(wv));
      chk("ifmap_vld", 32'(ifmap_vld_o), 32'(tt >= NW + 2 && tt <= NW + NI + 1));
      if (tt >= NW + 2 && tt <= NW + NI + 1) begin
         j = tt - NW - 2;
         chk("ifmap_row", 32'(ifmap_row_o), 32'(((j / W) % 2) == 0));
      end
      if (weight_vld_o != '0 || ifmap_vld_o) begin
         if (exp_q.size() == 0) chk("beat_expected", 32'(exp_q.size()), 1);
         else begin
            ed = exp_q.pop_front();
            chk("beat_data", (weight_vld_o != '0) ? 32'(weight_o) : 32'(ifmap_o), 32'(ed));
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic plan_clear();
      foreach (plan[i]) plan[i] = 1'b0;
   endtask

   task automatic plan_drain();
      int t;
      plan_clear();
      t = D_T;
      for (int k = 0; k < NOUT; k++) begin
         t += $urandom_range(0, 2);
         plan[t] = 1'b1;
         t++;
      end
   endtask

   task automatic plan_ifeed(input int n);
      int k, t;
      plan_clear();
      k = 0;
      while (k < n) begin
         t = $urandom_range(NW + 1, NW + NI);
         if (!plan[t]) begin
            plan[t] = 1'b1;
            k++;
         end
      end
   endtask

   task automatic plan_random();
      plan_clear();
      for (int t = 0; t < D_T + 8; t++) plan[t] = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < NOUT; k++) plan[D_T + 10 + k] = 1'b1;
   endtask

   // kill_kind: 0 none, 1 abort at cycle kill_at, 2 async reset at cycle kill_at.
   task automatic run(input logic [AW-1:0] wb, input logic [AW-1:0] ib, input int kill_at,
                      input int kill_kind, input bit hold, input bit abort_start);
      int cnt, p_t, done_t, t_end, k_at, k_kind;
      logic [AW-1:0] a;
      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
      cur_wb = wb;
      cur_ib = ib;
      exp_q.delete();
      for (int i = 0; i < NW; i++) begin a = wb + AW'(i); exp_q.push_back(mem[a]); end
      for (int j = 0; j < NI; j++) begin a = ib + AW'(j); exp_q.push_back(mem[a]); end
      // Pulses are counted from WLOAD on; DONE follows the later of DRAIN entry and the NOUT-th pulse.
      cnt = 0;
      p_t = PLAN_LEN;
      for (int t = 1; t < PLAN_LEN; t++)
         if (plan[t]) begin
            cnt++;
            if (cnt == NOUT) p_t = t;
         end
      done_t = ((p_t > D_T) ? p_t : D_T) + 1;
      k_at = kill_at;
      k_kind = kill_kind;
      if (hold) begin
         k_at = done_t + 2;
         k_kind = 1;
      end
      t_end = (k_kind != 0) ? k_at : done_t + 1;

      @(negedge clk_i);
      wt_base_i = wb;
      if_base_i = ib;
      start_i = 1'b1;
      abort_i = abort_start;
      psum_vld_i = 1'b0;
      for (int t = 0; t <= t_end; t++) begin
         @(negedge clk_i);
         if (!hold) start_i = 1'b0;
         abort_i = 1'b0;
         wt_base_i = AW'($urandom);
         if_base_i = AW'($urandom);
         check_cycle((hold && t >= done_t + 2) ? t - (done_t + 2) : t, done_t);
`ifdef PE_ARRAY_CTRL_PERF_EN
         if (t == done_t + 1) chk("perf_run", perf_cycles_o, 32'(done_t));
`endif
         psum_vld_i = (t < PLAN_LEN) ? plan[t] : 1'b0;
         if (t == k_at && k_kind == 1) abort_i = 1'b1;
         if (t == k_at && k_kind == 2) begin
            rst_ni = 1'b0;
            #1;
            check_idle("rst_async", 1'b1);
         end
      end

      if (k_kind == 0) begin
         psum_vld_i = 1'b0;
         chk("q_drained", 32'(exp_q.size()), 0);
      end else if (k_kind == 1) begin
         repeat (4) begin
            @(negedge clk_i);
            start_i = 1'b0;
            abort_i = 1'b0;
            psum_vld_i = 1'b0;
            check_idle("post_abort", 1'b0);
         end
      end else begin
         start_i = 1'b0;
         psum_vld_i = 1'b0;
         repeat (2) @(negedge clk_i);
         rst_ni = 1'b1;
         @(negedge clk_i);
         check_idle("post_reset", 1'b1);
`ifdef PE_ARRAY_CTRL_PERF_EN
         chk("perf_reset", perf_cycles_o, 0);
`endif
      end
      exp_q.delete();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      repeat (3) @(negedge clk_i);
      check_idle("in_reset", 1'b1);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check_idle("reset", 1'b1);
`ifdef PE_ARRAY_CTRL_PERF_EN
      chk("perf_init", perf_cycles_o, 0);
`endif
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      check_idle("idle_abort", 1'b1);

      plan_drain();   run(10'h010, 10'h020, -1, 0, 1'b0, 1'b0);
      plan_drain();   run(10'h010, 10'h3F8, -1, 0, 1'b0, 1'b0);
      plan_random();  run(AW'($urandom), AW'($urandom), NW + 5, 1, 1'b0, 1'b0);
      plan_random();  run(AW'($urandom), AW'($urandom), -1, 0, 1'b0, 1'b0);
      plan_drain();   run(AW'($urandom), AW'($urandom), -1, 0, 1'b1, 1'b0);
      plan_ifeed(6);  run(AW'($urandom), AW'($urandom), -1, 0, 1'b0, 1'b0);
      plan_random();  run(AW'($urandom), AW'($urandom), 4, 2, 1'b0, 1'b0);
      plan_random();  run(AW'($urandom), AW'($urandom), -1, 0, 1'b0, 1'b0);
      for (int r = 0; r < 4; r++) begin
         plan_random();
         run(AW'($urandom), AW'($urandom), -1, 0, 1'b0, r == 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
- Sequencer for a column of G_NUM_PE convolution PEs.
- On start, it clears the PE weights, then streams a KxK kernel from the global buffer into the PEs, one kernel row per PE.
- It then streams an HxW ifmap from the same buffer into the head of the PE ifmap chain.
- It counts psum_vld pulses from the tail PE and signals done once every output pixel has been produced.

Parameters:
G_BUF_ADDR_WIDTH, 10, buffer address width
G_TOP_BITS, 2, integer bits of fixed-point word
G_BOT_BITS, 14, fractional bits of fixed-point word
G_KERNEL_SIZE, 5, kernel dimension K
G_IMAGE_HEIGHT, 28, ifmap rows H
G_IMAGE_WIDTH, 28, ifmap columns W
G_NUM_PE, 5, PEs driven; must equal G_KERNEL_SIZE

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start pulse, sampled only in IDLE
abort_i  in  1  synchronous abort
wt_base_i  in  G_BUF_ADDR_WIDTH  kernel base address, captured on start
if_base_i  in  G_BUF_ADDR_WIDTH  ifmap base address, captured on start
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle completion pulse
buf_rd_en_o  out  1  buffer read strobe
buf_rd_addr_o  out  G_BUF_ADDR_WIDTH  buffer read address
buf_rd_data_i  in  G_TOP_BITS+G_BOT_BITS  read data, valid exactly 1 cycle after buf_rd_en_o
weight_clr_o  out  1  clear broadcast to all PEs
weight_vld_o  out  G_NUM_PE  per-PE weight write strobe, one-hot or zero
weight_o  out  G_TOP_BITS+G_BOT_BITS  weight data
ifmap_vld_o  out  1  ifmap valid into PE chain head
ifmap_row_o  out  1  row parity tag
ifmap_o  out  G_TOP_BITS+G_BOT_BITS  ifmap data
psum_vld_i  in  1  psum valid from tail PE

Behaviour:
- Reset: state IDLE. All outputs 0. All counters and captured bases 0.
- Derived constants:
  - NW = K*K
  - NI = H*W
  - NOUT = (H-K+1)*(W-K+1)
  - NI must not exceed 2^G_BUF_ADDR_WIDTH.
- Address arithmetic: base + index, modulo 2^G_BUF_ADDR_WIDTH; wrap-around is legal.
- States: IDLE, CLR, WLOAD, IFEED, DRAIN, DONE.
- IDLE: on start_i=1, capture both bases and go to CLR. start_i in any other state is ignored.
- CLR: one cycle.
  - weight_clr_o=1, no reads.
  - Clear psum count.
  - Go to WLOAD.
- WLOAD: NW cycles.
  - Read index i = 0..NW-1 at wt_base+i, with buf_rd_en_o=1.
  - Word i is kernel row r=i/K, column c=i%K, row-major in memory.
  - One cycle after the read, weight_vld_o[r]=1 and weight_o=buf_rd_data_i.
  - After read NW-1 is issued, go to IFEED; the final weight strobe lands in IFEED's first cycle.
- IFEED: NI cycles, one read per cycle at if_base+j.
  - One cycle after each read: ifmap_vld_o=1, ifmap_o=buf_rd_data_i.
  - ifmap_row_o=1 for image rows 0,2,4,... and 0 for rows 1,3,...
  - After read NI-1, go to DRAIN; the final ifmap beat lands in DRAIN's first cycle.
- Data pipeline: read-data output registers are driven purely from a 1-cycle delayed copy of the read strobe and index. buf_rd_en_o is never high in CLR, DRAIN, DONE or IDLE.
- Psum counting: psum_vld_i is counted in WLOAD, IFEED and DRAIN. The count saturates at NOUT; extra pulses are ignored.
- DRAIN: when count==NOUT (including a pulse arriving that same cycle), go to DONE.
- DONE: done_o=1 for one cycle, then IDLE. busy_o is 1 in DONE.
- abort_i=1 in any non-IDLE state:
  - Next cycle is IDLE.
  - All strobes and the delayed data pipeline are cleared in that same edge, so no trailing weight or ifmap beat.
  - done_o is not asserted.
  - abort_i has priority over every other transition.
- abort_i in IDLE: no effect. Simultaneous start_i and abort_i in IDLE: start wins.
- Asynchronous reset mid-operation: immediate return to the reset values above.

Optional Feature:
- Macro: PE_ARRAY_CTRL_PERF_EN.
- When defined:
  - Adds output perf_cycles_o, 32 bits.
  - Cleared on entering CLR.
  - Increments every cycle in CLR..DRAIN, saturating at all ones.
  - Holds its value in DONE and IDLE until the next start.
  - Reset value 0.
- When undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- K=3, H=W=4, wt_base=0x010, if_base=0x020; start, tail model pulses psum_vld_i 4 times during DRAIN -> exactly one weight_clr_o cycle; 9 reads at 0x010-0x018; weight_vld_o sequence 001x3, 010x3, 100x3; 16 ifmap beats with ifmap_row_o pattern 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0; done_o pulses once.
- if_base=0x3F8 with H=W=4 -> read addresses run 0x3F8..0x3FF then 0x000..0x007, with no gap.
- abort_i asserted on the 5th IFEED cycle -> busy_o=0 next cycle, no ifmap_vld_o afterwards, done_o never asserted; a subsequent start completes normally.
- start_i held high throughout a whole run -> exactly one CLR per entry from IDLE, i.e. a new run starts only on the cycle after DONE.
- 6 psum_vld_i pulses with NOUT=4, all arriving during IFEED -> DONE is reached on the first DRAIN cycle after the last ifmap read; no count overflow.
- Reset asserted mid-WLOAD, then released -> all outputs 0 and state IDLE; with PE_ARRAY_CTRL_PERF_EN, perf_cycles_o=0 after reset and equals the CLR-through-DRAIN cycle count after a full run.
